credit_tx_port: RTL

CREDIT_TX_PORT -- requirements
Module: credit_tx_port

---
 rtl/credit_tx_pkg.sv | 8 +
 rtl/credit_tx_port.sv | 116 +++++++++++
 2 files changed

// File: rtl/credit_tx_pkg.sv
// Flit format shared by the credit transmit port and its users.
// The vc field is two bits wide, which covers up to four virtual channels.
package credit_tx_pkg;
  typedef struct packed {
    logic [1:0]  vc;
    logic [31:0] data;
  } flit_t;
endpackage

// File: rtl/credit_tx_port.sv
// Credit-based transmit port: per-VC staging FIFOs, a round-robin arbiter over
// the VCs that hold both data and credit, and one registered flit per cycle.
module credit_tx_port
  import credit_tx_pkg::*;
#(
  parameter int NUM_VCS     = 2,
  parameter int DEPTH       = 8,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                                     clk,
  input  logic                                     n_rst,
  input  logic                                     in_valid,
  input  flit_t                                    in_flit,
  output logic                                     in_ready,
  output logic                                     data_ready_out,
  output flit_t                                    out,
  input  logic [NUM_VCS-1:0]                       credit_granted,
  output logic [NUM_VCS-1:0][$clog2(DEPTH+1)-1:0] credits,
  output logic                                     credit_error
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int QW = $clog2(QUEUE_DEPTH);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [QW:0]        wr_ptr [NUM_VCS];
  logic [QW:0]        rd_ptr [NUM_VCS];
  flit_t              mem    [NUM_VCS][QUEUE_DEPTH];

  logic [NUM_VCS-1:0] full;
  logic [NUM_VCS-1:0] empty;
  logic [NUM_VCS-1:0] eligible;
  logic [NUM_VCS-1:0] push;
  logic [NUM_VCS-1:0] pop;
  logic               grant_valid;
  logic [1:0]         grant_vc;
  logic [1:0]         last_vc;
  flit_t              head;

  always_comb begin
    in_ready = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      empty[v]    = (wr_ptr[v] == rd_ptr[v]);
      full[v]     = (wr_ptr[v][QW] != rd_ptr[v][QW]) &&
                    (wr_ptr[v][QW-1:0] == rd_ptr[v][QW-1:0]);
      eligible[v] = !empty[v] && (credits[v] != '0);
      if (int'(in_flit.vc) == v) in_ready = !full[v];
    end
  end

  // Search VCs above the last winner first, then wrap to VC0..last.
  always_comb begin
    grant_valid = 1'b0;
    grant_vc    = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (!grant_valid && eligible[v] && (v > int'(last_vc))) begin
        grant_valid = 1'b1;
        grant_vc    = 2'(v);
      end
    end
    for (int v = 0; v < NUM_VCS; v++) begin
      if (!grant_valid && eligible[v] && (v <= int'(last_vc))) begin
        grant_valid = 1'b1;
        grant_vc    = 2'(v);
      end
    end
  end

  always_comb begin
    head = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      push[v] = in_valid && in_ready && (int'(in_flit.vc) == v);
      pop[v]  = grant_valid && (int'(grant_vc) == v);
      if (pop[v]) head = mem[v][rd_ptr[v][QW-1:0]];
    end
    head.vc = grant_vc;
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (push[v]) mem[v][wr_ptr[v][QW-1:0]] <= in_flit;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        wr_ptr[v]  <= '0;
        rd_ptr[v]  <= '0;
        credits[v] <= CW'(DEPTH);
      end
      data_ready_out <= 1'b0;
      out            <= '0;
      credit_error   <= 1'b0;
      last_vc        <= 2'(NUM_VCS - 1);
    end else begin
      data_ready_out <= grant_valid;
      if (grant_valid) begin
        out     <= head;
        last_vc <= grant_vc;
      end
      for (int v = 0; v < NUM_VCS; v++) begin
        if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (pop[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
        // A return that coincides with a send on the same VC cancels out.
        if (credit_granted[v] && !pop[v]) begin
          if (credits[v] == CW'(DEPTH)) credit_error <= 1'b1;
          else                          credits[v]   <= credits[v] + 1'b1;
        end else if (pop[v] && !credit_granted[v]) begin
          credits[v] <= credits[v] - 1'b1;
        end
      end
    end
  end

endmodule
